// File: rtl/pulse_burst_scheduler.sv
// Pulse burst scheduler: four requesters share one pulse output. A
// round-robin arbiter picks an owner, whose period and burst count are
// latched; the owner then receives a train of pulses spaced P+1 enabled
// cycles apart until the burst completes or the owner drops its request.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no owner; arbitrate among active requests
//   RUN   | owner granted; period counter runs while ena is high
//   DONE  | one-cycle completion strobe to the owner, then back to IDLE
module pulse_burst_scheduler #(
    parameter int N = 8,
    parameter int C = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ena,
    input  logic [3:0]     req,
    input  logic [4*N-1:0] period,
    input  logic [4*C-1:0] count,
    output logic [3:0]     grant,
    output logic           out,
    output logic           busy,
    output logic [3:0]     done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [1:0]   owner;
    logic [1:0]   owner_nxt;
    logic [1:0]   last;
    logic [1:0]   last_nxt;
    logic [N-1:0] cnt;
    logic [N-1:0] cnt_nxt;
    logic [N-1:0] per;
    logic [N-1:0] per_nxt;
    logic [C-1:0] rem;
    logic [C-1:0] rem_nxt;

    logic [1:0]   win;
    logic         win_vld;
    logic [N-1:0] win_per;
    logic [C-1:0] win_cnt;
    logic         owner_req;
    logic         fire;

    // Round-robin search starting just after the previous owner.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!win_vld && req[last + 2'(k)]) begin
                win     = last + 2'(k);
                win_vld = 1'b1;
            end
        end
    end

    assign win_per   = period[int'(win)*N +: N];
    assign win_cnt   = count[int'(win)*C +: C];
    assign owner_req = req[owner];

    // A pulse needs the owner still requesting; an abort cycle never pulses.
    assign fire = (state == RUN) && ena && owner_req && (cnt == per);
    assign out  = fire;

    // Grant and done decode straight from the state register.
    always_comb begin
        grant = 4'b0000;
        done  = 4'b0000;
        if (state != IDLE) begin
            grant = 4'b0001 << owner;
        end
        if (state == DONE) begin
            done = 4'b0001 << owner;
        end
        busy = |grant;
    end

    // Next-state and datapath updates.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last;
        cnt_nxt   = cnt;
        per_nxt   = per;
        rem_nxt   = rem;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    owner_nxt = win;
                    per_nxt   = win_per;
                    rem_nxt   = win_cnt;
                    cnt_nxt   = '0;
                    state_nxt = (win_cnt != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (!owner_req) begin
                    state_nxt = IDLE;
                    last_nxt  = owner;
                    cnt_nxt   = '0;
                    rem_nxt   = '0;
                end else if (ena) begin
                    if (cnt == per) begin
                        cnt_nxt = '0;
                        rem_nxt = rem - C'(1);
                        if (rem == C'(1)) begin
                            state_nxt = DONE;
                        end
                    end else begin
                        cnt_nxt = cnt + N'(1);
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                last_nxt  = owner;
                cnt_nxt   = '0;
                rem_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register; last resets to 3 so requester 0 has first priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            owner <= 2'd0;
            last  <= 2'd3;
            cnt   <= '0;
            per   <= '0;
            rem   <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
            per   <= per_nxt;
            rem   <= rem_nxt;
        end
    end

endmodule

// File: tb/tb_pulse_burst_scheduler.sv
// Bench for pulse_burst_scheduler: directed scenarios followed by random
// traffic, all checked against a burst-level reference model.
module tb_pulse_burst_scheduler;

    localparam int N = 8;
    localparam int C = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           ena = 1'b0;
    logic [3:0]     req = 4'b0000;
    logic [4*N-1:0] period = '0;
    logic [4*C-1:0] count = '0;
    logic [3:0]     grant;
    logic           out;
    logic           busy;
    logic [3:0]     done;

    int n_chk = 0;
    int n_err = 0;

    // reference model: one burst record
    bit m_busy    = 1'b0;
    bit m_closing = 1'b0;
    int m_owner   = 0;
    int m_last    = 3;
    int m_p       = 0;
    int m_k       = 0;
    int m_en      = 0;
    int m_fired   = 0;

    int seen_out     = 0;
    bit seen_done    = 1'b0;
    int cyc          = 0;
    int last_out_cyc = 0;
    int gap          = 0;

    pulse_burst_scheduler #(.N(N), .C(C)) dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .req    (req),
        .period (period),
        .count  (count),
        .grant  (grant),
        .out    (out),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_busy    = 1'b0;
        m_closing = 1'b0;
        m_last    = 3;
    endtask

    // One clock cycle: check outputs at the falling edge, advance the model,
    // return just after the rising edge so the caller can change inputs.
    task automatic cycle();
        logic [3:0] e_grant;
        logic [3:0] e_done;
        logic       e_out;
        bit         abrt;
        bit         pulse;
        @(negedge clk);
        e_grant = 4'b0000;
        e_done  = 4'b0000;
        e_out   = 1'b0;
        abrt    = 1'b0;
        pulse   = 1'b0;
        if (m_busy) begin
            e_grant = 4'b0001 << m_owner;
            if (m_closing) begin
                e_done = e_grant;
            end else begin
                abrt  = !req[m_owner];
                pulse = !abrt && ena && (((m_en + 1) % (m_p + 1)) == 0);
                e_out = pulse;
            end
        end
        chk("grant", grant, e_grant);
        chk("done",  done,  e_done);
        chk("out",   out,   e_out);
        chk("busy",  busy,  |e_grant);
        if (out) begin
            seen_out++;
            gap          = cyc - last_out_cyc;
            last_out_cyc = cyc;
        end
        if (done != 4'b0000) seen_done = 1'b1;

        if (!m_busy) begin
            if (req != 4'b0000) begin
                for (int k = 1; k <= 4; k++) begin
                    int i;
                    i = (m_last + k) % 4;
                    if (req[i]) begin
                        m_owner = i;
                        break;
                    end
                end
                m_p       = int'(period[m_owner*N +: N]);
                m_k       = int'(count[m_owner*C +: C]);
                m_busy    = 1'b1;
                m_en      = 0;
                m_fired   = 0;
                m_closing = (m_k == 0);
            end
        end else if (m_closing) begin
            m_busy    = 1'b0;
            m_closing = 1'b0;
            m_last    = m_owner;
        end else if (abrt) begin
            m_busy = 1'b0;
            m_last = m_owner;
        end else if (ena) begin
            m_en++;
            if (pulse) begin
                m_fired++;
                if (m_fired == m_k) m_closing = 1'b1;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_done(input int maxc);
        seen_done = 1'b0;
        for (int c = 0; c < maxc && !seen_done; c++) cycle();
        chk("done_reached", seen_done, 1);
    endtask

    task automatic run_until_out(input int maxc);
        seen_out = 0;
        for (int c = 0; c < maxc && seen_out == 0; c++) cycle();
        chk("out_reached", (seen_out != 0), 1);
    endtask

    // Asynchronous reset pulse starting between clock edges.
    task automatic pulse_reset();
        #1;
        rst = 1'b0;
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_done",  done,  0);
        chk("rst_out",   out,   0);
        chk("rst_busy",  busy,  0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("init_grant", grant, 0);
        chk("init_busy",  busy,  0);
        chk("init_out",   out,   0);
        chk("init_done",  done,  0);
        rst = 1'b1;
        ena = 1'b1;
        model_reset();

        // single burst P=2, K=3
        period = 32'h0000_0002;
        count  = 16'h0003;
        req    = 4'b0001;
        seen_out = 0;
        run_until_done(40);
        chk("p0_pulses", seen_out, 3);
        chk("p0_gap", gap, 3);
        req = 4'b0000;
        cycle();

        // all requesting, K=1, P=0: round-robin rotation
        period = '0;
        count  = 16'h1111;
        req    = 4'b1111;
        repeat (15) cycle();
        req = 4'b0000;
        repeat (3) cycle();

        // zero-length burst
        count  = 16'h0000;
        req    = 4'b0100;
        seen_out = 0;
        run_until_done(10);
        chk("k0_pulses", seen_out, 0);
        req = 4'b0000;
        cycle();

        // enable gap between pulses of a P=3, K=2 burst
        period = 32'h0000_0300;
        count  = 16'h0020;
        req    = 4'b0010;
        run_until_out(20);
        cycle();
        ena = 1'b0;
        repeat (5) cycle();
        ena = 1'b1;
        run_until_done(40);
        chk("ena_gap", gap, 9);
        req = 4'b0000;
        cycle();

        // abort after the first of four pulses, pending requester takes over
        period = 32'h0000_0001;
        count  = 16'h0014;
        req    = 4'b0011;
        run_until_out(20);
        req = 4'b0010;
        repeat (2) cycle();
        chk("abort_handover", grant, 4'b0010);
        run_until_done(20);
        req = 4'b0000;
        cycle();

        // reset mid-burst, then requester 0 has priority
        period = 32'h0000_0002;
        count  = 16'h0003;
        req    = 4'b0001;
        repeat (4) cycle();
        pulse_reset();
        req = 4'b1001;
        cycle();
        chk("rst_winner", grant, 4'b0001);
        run_until_done(40);
        req = 4'b0000;
        cycle();

        // random traffic
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 7) == 0) req[$urandom_range(0, 3)] = ~req[$urandom_range(0, 3)];
            if ($urandom_range(0, 7) == 0) req = req ^ (4'b0001 << $urandom_range(0, 3));
            ena = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) period = $urandom & 32'h0303_0303;
            if ($urandom_range(0, 3) == 0) count  = 16'($urandom) & 16'h3333;
            if ($urandom_range(0, 499) == 0) pulse_reset();
            else cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pulse_burst_scheduler.md
PULSE_BURST_SCHEDULER -- requirements
Module: pulse_burst_scheduler

Interface
REQ-001 SHALL have parameter N, default 8, the width of each period field.
REQ-002 SHALL have parameter C, default 4, the width of each burst-count field.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ena  input  1  global enable; low pauses the period counter.
REQ-006 SHALL have port req  input  4  per-requester burst request, held high until done or abort.
REQ-007 SHALL have port period  input  4*N  packed periods; requester i uses bits [i*N +: N].
REQ-008 SHALL have port count  input  4*C  packed burst lengths; requester i uses bits [i*C +: C].
REQ-009 SHALL have port grant  output  4  one-hot owner of the pulse train; all zero when idle.
REQ-010 SHALL have port out  output  1  shared pulse output.
REQ-011 SHALL have port busy  output  1  high while any burst is owned.
REQ-012 SHALL have port done  output  4  one-cycle completion strobe, one bit per requester.

Function
REQ-013 SHALL implement states IDLE, RUN and DONE.
REQ-014 IDLE, any req high: SHALL pick the winner round-robin, searching from index (last+1) mod 4.
REQ-015 On leaving IDLE SHALL latch the winner's period P and count K; later changes on period/count SHALL NOT affect the active burst.
REQ-016 IDLE with K != 0 SHALL go to RUN on the next edge.
REQ-017 IDLE with K == 0 SHALL go directly to DONE, and no pulse SHALL be issued.
REQ-018 grant SHALL be high for the winner in RUN and DONE; busy SHALL equal |grant.
REQ-019 On entry to RUN, the N-bit period counter SHALL be 0 and the pulses-remaining register SHALL be K.
REQ-020 RUN, ena high, counter != P: the counter SHALL increment by 1.
REQ-021 RUN, ena high, counter == P: out SHALL be 1 that cycle, the counter SHALL clear to 0, and pulses-remaining SHALL decrement.
REQ-022 Pulse spacing SHALL be P+1 enabled cycles; P=0 SHALL give a pulse every enabled cycle.
REQ-023 ena low: the counter and pulses-remaining SHALL hold, and out SHALL be 0.
REQ-024 out SHALL be combinational from state, counter and ena, with no extra register stage.
REQ-025 First-pulse latency: req sampled in IDLE at edge t gives grant from t+1, and the first out in the cycle after edge t+1+P (all cycles enabled).
REQ-026 When the pulse that decrements pulses-remaining from 1 to 0 is issued, the next state SHALL be DONE.
REQ-027 DONE SHALL last exactly one cycle, with done[winner]=1 and out=0.
REQ-028 DONE SHALL set last to the winner index and go to IDLE; grant SHALL drop on that edge.
REQ-029 A requester SHALL be re-grantable no earlier than the IDLE cycle after DONE; IDLE always lasts at least one cycle.
REQ-030 Abort: req[winner] low during RUN SHALL go to IDLE on the next edge.
REQ-031 On abort, done SHALL NOT pulse and last SHALL still update to the winner.
REQ-032 An aborted burst's out SHALL be suppressed in the cycle req is seen low.
REQ-033 Requests from non-owners during RUN/DONE SHALL be ignored until IDLE; no queuing beyond a held req.
REQ-034 The counter SHALL never exceed P; any N-bit overflow is impossible by construction.

Reset
REQ-035 While rst=0, state SHALL be IDLE, counter 0, pulses-remaining 0, and last 3, so req[0] has first priority.
REQ-036 While rst=0, grant, done, out and busy SHALL all be 0, asserted asynchronously.
REQ-037 Reset asserted mid-burst SHALL abort immediately, with no done strobe.
REQ-038 After rst rises, operation SHALL resume on the first rising clk edge.

Verification
REQ-039 req=0001, P0=2, K0=3, ena=1 -> grant=0001 for 10 cycles; out high 3 cycles, 3 apart; done[0] 1 cycle; busy then 0.
REQ-040 req=1111 held, all K=1, P=0 -> grants in order 0,1,2,3,0, each 2 cycles owned plus 1 IDLE cycle.
REQ-041 P1=3, K1=2, ena low for 5 cycles mid-count -> counter frozen and out 0; pulse spacing grows by exactly 5 cycles.
REQ-042 K2=0 with req=0100 -> grant 1 cycle, done[2] 1 cycle, out never high.
REQ-043 Drop req[0] after the first of 4 pulses -> IDLE next edge, no done; pending req[1] granted next.
REQ-044 rst=0 pulsed mid-burst -> all outputs 0 immediately; after release, req=1000 and req=0001 together -> req[0] wins.
